piso_bit_serializer: RTL and testbench
======================================

Name: piso_bit_serializer

Overview:
- Parallel-in, serial-out stage directly upstream of the serial pattern detector.
- Accepts a WIDTH-bit word over a valid/ready handshake and drives it onto the single-bit `out` line, one bit per `clk`.
- `out` connects straight to the detector's serial `in`; `out_valid` and `frame_done` are for bench and system monitoring.

Parameters:
- WIDTH, 8: word width in bits; must be at least 2.
- MSB_FIRST, 1: 1 shifts bit WIDTH-1 first; 0 shifts bit 0 first.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  WIDTH  word to serialize; sampled only on handshake.
- load_valid  input  1  producer has a word on data_in.
- load_ready  output  1  block can accept a word this cycle.
- out  output  1  current serial bit; feeds detector `in`.
- out_valid  output  1  `out` carries a real data bit this cycle.
- busy  output  1  high while a word is being shifted.
- frame_done  output  1  one-cycle pulse, high while the last bit of a word is on `out`.

Behaviour:
- Reset (sampled at a clk edge while reset=1):
  - State goes to IDLE; shift register, bit counter and hold buffer are cleared.
  - Registered outputs after that edge: out=0, out_valid=0, busy=0, frame_done=0.
  - load_ready is forced 0 while reset=1.
  - Reset has priority over everything, including mid-word; the partial word is discarded and nothing further is emitted.
- Handshake: a transfer occurs on a clk edge where load_valid=1 and load_ready=1. Outside a transfer, data_in is ignored. load_ready is combinational from state.
- States: IDLE, SHIFT.
- IDLE:
  - load_ready=1, out=0, out_valid=0, busy=0.
  - On transfer: shreg<=data_in, cnt<=0, go to SHIFT.
  - Latency: the first bit appears on `out` in the cycle right after the transfer edge.
- SHIFT:
  - out = shreg[WIDTH-1] when MSB_FIRST=1, else shreg[0].
  - out_valid=1, busy=1.
  - Each edge: shift shreg toward the output end (zero fill) and increment cnt.
  - frame_done=1 while cnt==WIDTH-1.
  - On the edge leaving cnt==WIDTH-1: return to IDLE, unless the optional feature reloads.
- Word length: exactly WIDTH consecutive cycles with out_valid=1 per word, with no gaps inside a word.
- Counter: cnt is $clog2(WIDTH) bits wide and never exceeds WIDTH-1.
- Load while busy: base build holds load_ready=0 in SHIFT. load_valid is ignored there, and the producer must hold its word.
- Word-to-word gap in the base build: exactly one IDLE cycle between consecutive words (out=0, out_valid=0).
  - The downstream detector sees that gap as a 0 bit. System integrators must account for this.

Optional Feature:
- Macro: PISO_HOLD_BUFFER_EN.
- With the macro defined:
  - Adds a one-entry hold buffer (hbuf, hfull).
  - In SHIFT, load_ready = !hfull. A transfer in SHIFT writes hbuf and sets hfull.
  - On the last-bit edge with hfull=1: shreg<=hbuf, cnt<=0, hfull<=0, and the block stays in SHIFT. Words stream with no gap.
  - A transfer on that same last-bit edge while hfull=0: the new word goes directly into shreg, also with no gap.
  - hfull is cleared by reset.
- Without the macro: base behaviour only. There is no hbuf logic and there is a mandatory one-cycle gap.

Test Plan:
1. WIDTH=8, MSB_FIRST=1, transfer 8'hB4 at edge T -> `out` = 1,0,1,1,0,1,0,0 on cycles T+1..T+8; out_valid=1 throughout; frame_done only at T+8; IDLE at T+9 with out=0.
2. MSB_FIRST=0, transfer 8'hB4 -> `out` = 0,0,1,0,1,1,0,1; frame_done pulse on the 8th bit; busy falls afterwards.
3. Hold load_valid=1 with 8'hFF during SHIFT (base build) -> load_ready=0, and no capture until IDLE. The second word starts exactly 1 gap cycle after the first ends.
4. Assert reset for 1 cycle at the 4th bit of 8'hB4 -> next cycle out=0, out_valid=0, busy=0, load_ready=1. The remaining 4 bits are never emitted.
5. With PISO_HOLD_BUFFER_EN, send 8'hB4 then 8'h5A back-to-back -> 16 contiguous valid bits 10110100 01011010, and frame_done pulses at bits 8 and 16.
6. Chain with the detector, sending 8'hB0 (1,0,1,1,0,0,0,0) -> the detector asserts its output after the fifth serial bit (pattern 10110). No assertion occurs for 8'h00.

Source files
------------

// File: rtl/piso_bit_serializer.sv
// Parallel-in, serial-out bit serializer with valid/ready load handshake.
// Optional macro PISO_HOLD_BUFFER_EN adds a one-entry hold buffer for gapless word streaming.
module piso_bit_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             frame_done
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             out_n, out_valid_n, busy_n, frame_done_n;
  logic             ready;
  logic             xfer;
  logic             last_bit;

`ifdef PISO_HOLD_BUFFER_EN
  logic [WIDTH-1:0] hbuf, hbuf_n;
  logic             hfull, hfull_n;
`endif

  // Bit that sits at the output end of a word for the configured order.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Move the word one place toward the output end, zero filling behind it.
  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  // Load acceptance is a pure function of state; reset masks it.
  always_comb begin
    ready = 1'b0;
    if (!reset) begin
      unique case (state)
        IDLE:  ready = 1'b1;
`ifdef PISO_HOLD_BUFFER_EN
        SHIFT: ready = !hfull;
`else
        SHIFT: ready = 1'b0;
`endif
        default: ready = 1'b0;
      endcase
    end
  end

  assign load_ready = ready;
  assign xfer       = load_valid && ready;
  assign last_bit   = (cnt == LAST_CNT);

  // Next-state, datapath and next-output logic.
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    cnt_n   = cnt;
`ifdef PISO_HOLD_BUFFER_EN
    hbuf_n  = hbuf;
    hfull_n = hfull;
`endif

    unique case (state)
      IDLE: begin
        if (xfer) begin
          shreg_n = data_in;
          cnt_n   = '0;
          state_n = SHIFT;
        end
      end

      SHIFT: begin
        if (last_bit) begin
`ifdef PISO_HOLD_BUFFER_EN
          if (hfull) begin
            shreg_n = hbuf;
            cnt_n   = '0;
            hfull_n = 1'b0;
          end else if (xfer) begin
            shreg_n = data_in;
            cnt_n   = '0;
          end else begin
            shreg_n = '0;
            cnt_n   = '0;
            state_n = IDLE;
          end
`else
          shreg_n = '0;
          cnt_n   = '0;
          state_n = IDLE;
`endif
        end else begin
          shreg_n = shift_word(shreg);
          cnt_n   = cnt + CNT_W'(1);
`ifdef PISO_HOLD_BUFFER_EN
          if (xfer) begin
            hbuf_n  = data_in;
            hfull_n = 1'b1;
          end
`endif
        end
      end

      default: begin
        state_n = IDLE;
        shreg_n = '0;
        cnt_n   = '0;
      end
    endcase

    out_n        = 1'b0;
    out_valid_n  = 1'b0;
    busy_n       = 1'b0;
    frame_done_n = 1'b0;
    if (state_n == SHIFT) begin
      out_n        = head_bit(shreg_n);
      out_valid_n  = 1'b1;
      busy_n       = 1'b1;
      frame_done_n = (cnt_n == LAST_CNT);
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= '0;
      cnt        <= '0;
      out        <= 1'b0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      cnt        <= cnt_n;
      out        <= out_n;
      out_valid  <= out_valid_n;
      busy       <= busy_n;
      frame_done <= frame_done_n;
    end
  end

`ifdef PISO_HOLD_BUFFER_EN
  // Hold buffer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      hbuf  <= '0;
      hfull <= 1'b0;
    end else begin
      hbuf  <= hbuf_n;
      hfull <= hfull_n;
    end
  end
`endif

endmodule

// File: tb/tb_piso_bit_serializer.sv
// Scoreboard bench for piso_bit_serializer: MSB-first and LSB-first instances share one stimulus.
module tb_piso_bit_serializer;

`ifdef PISO_HOLD_BUFFER_EN
  localparam int B2B_GAP = 0;
`else
  localparam int B2B_GAP = 1;
`endif

  logic       clk;
  logic       reset;
  logic [7:0] data_in;
  logic       load_valid;
  logic       load_ready_m, out_m, out_valid_m, busy_m, frame_done_m;
  logic       load_ready_l, out_l, out_valid_l, busy_l, frame_done_l;

  typedef struct {
    logic b;
    logic fd;
    int   gap;
  } exp_t;

  exp_t q_m[$];
  exp_t q_l[$];
  int   n_checks;
  int   n_fail;
  int   idle_m;
  int   idle_l;
  bit   mon_en;

  piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .load_valid (load_valid),
    .load_ready (load_ready_m),
    .out        (out_m),
    .out_valid  (out_valid_m),
    .busy       (busy_m),
    .frame_done (frame_done_m)
  );

  piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .load_valid (load_valid),
    .load_ready (load_ready_l),
    .out        (out_l),
    .out_valid  (out_valid_l),
    .busy       (busy_l),
    .frame_done (frame_done_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare one valid output cycle against the next queued expectation.
  task automatic score(input string nm, input bit have, input exp_t e, input logic o,
                       input logic fd, input logic bz, input int idle);
    if (!have) begin
      check({nm, "_unexpected_bit"}, 32'(1), 32'(0));
    end else begin
      check({nm, "_out"}, 32'(o), 32'(e.b));
      check({nm, "_frame_done"}, 32'(fd), 32'(e.fd));
      check({nm, "_busy"}, 32'(bz), 32'(1));
      if (e.gap >= 0) check({nm, "_gap"}, 32'(idle), 32'(e.gap));
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    bit   have;
    if (mon_en) begin
      check("ready_match", 32'(load_ready_l), 32'(load_ready_m));
      if (out_valid_m) begin
        have = (q_m.size() > 0);
        if (have) e = q_m.pop_front();
        score("msb", have, e, out_m, frame_done_m, busy_m, idle_m);
        idle_m = 0;
      end else begin
        check("msb_idle_out", 32'({out_m, busy_m, frame_done_m}), 32'(0));
        idle_m++;
      end
      if (out_valid_l) begin
        have = (q_l.size() > 0);
        if (have) e = q_l.pop_front();
        score("lsb", have, e, out_l, frame_done_l, busy_l, idle_l);
        idle_l = 0;
      end else begin
        check("lsb_idle_out", 32'({out_l, busy_l, frame_done_l}), 32'(0));
        idle_l++;
      end
    end
  end

  task automatic push_word(input logic [7:0] w, input int gap);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      e.fd  = (i == 7);
      e.gap = (i == 0) ? gap : -1;
      e.b   = w[7-i];
      q_m.push_back(e);
      e.b   = w[i];
      q_l.push_back(e);
    end
  endtask

  // Offer a word and hold it until accepted; runs at posedge+1.
  task automatic send(input logic [7:0] w, input int gap);
    bit got;
    got        = 1'b0;
    data_in    = w;
    load_valid = 1'b1;
    for (int n = 0; n < 100 && !got; n++) begin
`ifndef PISO_HOLD_BUFFER_EN
      check("ready_vs_busy", 32'(load_ready_m), 32'(!busy_m));
`endif
      if (load_ready_m) got = 1'b1;
      else @(posedge clk) #1;
    end
    if (got) begin
      push_word(w, gap);
      @(posedge clk) #1;
    end else begin
      check("handshake_timeout", 32'(0), 32'(1));
    end
    load_valid = 1'b0;
    data_in    = 8'($urandom);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 200 && !done; n++) begin
      if (q_m.size() == 0 && q_l.size() == 0 && !busy_m) done = 1'b1;
      else @(posedge clk) #1;
    end
    if (!done) check("drain_timeout", 32'(0), 32'(1));
    repeat (2) @(posedge clk) #1;
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    idle_m     = 0;
    idle_l     = 0;
    mon_en     = 1'b0;
    reset      = 1'b1;
    load_valid = 1'b0;
    data_in    = 8'h00;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("ready_in_reset", 32'(load_ready_m), 32'(0));
    check("reset_outs", 32'({out_m, out_valid_m, busy_m, frame_done_m}), 32'(0));
    reset = 1'b0;
    #1;
    check("ready_after_reset", 32'(load_ready_m), 32'(1));
    mon_en = 1'b1;
    repeat (2) @(posedge clk) #1;

    // Single word in both bit orders
    send(8'hB4, -1);
    drain();

    // Second word held on data_in while the first shifts
    send(8'hB4, -1);
    send(8'hFF, B2B_GAP);
    drain();

    // Reset during the fourth bit discards the rest of the word
    send(8'hB4, -1);
    repeat (4) @(negedge clk);
    #1;
    reset = 1'b1;
    q_m.delete();
    q_l.delete();
    #1;
    check("ready_mid_reset", 32'(load_ready_m), 32'(0));
    @(posedge clk) #1;
    reset = 1'b0;
    check("post_reset_outs", 32'({out_m, out_valid_m, busy_m, frame_done_m}), 32'(0));
    #1;
    check("post_reset_ready", 32'(load_ready_m), 32'(1));
    repeat (12) @(posedge clk) #1;

    // Back-to-back words, then a random stream
    send(8'hB4, -1);
    send(8'h5A, B2B_GAP);
    drain();
    send(8'($urandom), -1);
    for (int k = 0; k < 4; k++) send(8'($urandom), B2B_GAP);
    drain();
    send(8'h00, -1);
    send(8'h01, B2B_GAP);
    send(8'h80, B2B_GAP);
    drain();

    check("queue_empty", 32'(q_m.size() + q_l.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
